// File: rtl/decoder_stage_if.sv
// decoder_stage_if: fetch-side and execute-side handshake/bus signals of the
// RV32I/M decode stage.
//   slave  : the decode stage's view (consumes fetch inputs, drives bundle).
//   master : the environment's view (drives fetch inputs and I_ready).
// Signals:
//   I_flush            discard buffered entries and the current input
//   I_valid/O_ready    fetch-side handshake, I_instr/I_pc payload
//   O_valid/I_ready    execute-side handshake
//   O_pc .. O_illegal  decoded control bundle of the head entry
interface decoder_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            I_flush;
    logic            I_valid;
    logic            O_ready;
    logic [31:0]     I_instr;
    logic [XLEN-1:0] I_pc;

    logic            O_valid;
    logic            I_ready;
    logic [XLEN-1:0] O_pc;
    logic [4:0]      O_rs1;
    logic [4:0]      O_rs2;
    logic [4:0]      O_rd;
    logic [XLEN-1:0] O_imm;
    logic [5:0]      O_branchmask;
    logic [2:0]      O_funct3;
    logic [4:0]      O_alu_oper;
    logic            O_alu_s1_sel;
    logic [1:0]      O_alu_s2_sel;
    logic [2:0]      O_next_stage;
    logic            O_wb_from_alu;
    logic            O_wb_from_imm;
    logic            O_next_pc_from_alu;
    logic [1:0]      O_reg_input_sel;
    logic            O_illegal;

    modport slave (
        input  I_flush, I_valid, I_instr, I_pc, I_ready,
        output O_ready, O_valid, O_pc, O_rs1, O_rs2, O_rd, O_imm,
               O_branchmask, O_funct3, O_alu_oper, O_alu_s1_sel,
               O_alu_s2_sel, O_next_stage, O_wb_from_alu, O_wb_from_imm,
               O_next_pc_from_alu, O_reg_input_sel, O_illegal
    );

    modport master (
        output I_flush, I_valid, I_instr, I_pc, I_ready,
        input  O_ready, O_valid, O_pc, O_rs1, O_rs2, O_rd, O_imm,
               O_branchmask, O_funct3, O_alu_oper, O_alu_s1_sel,
               O_alu_s2_sel, O_next_stage, O_wb_from_alu, O_wb_from_imm,
               O_next_pc_from_alu, O_reg_input_sel, O_illegal
    );
endinterface

// File: rtl/decoder_stage.sv
// decoder_stage: registered RV32I/M decode stage between fetch and execute.
// Instructions are decoded combinationally on I_instr and pushed into a
// DEPTH-entry FIFO; the head entry drives the control bundle.
// Ports:
//   I_clk, I_rst_n   clock (rising edge), asynchronous active-low reset
//   bus (slave)      fetch/execute handshakes and decoded bundle
//   O_perf_decoded   (DECODER_STAGE_PERF_EN only) saturating count of legal pops
//   O_perf_illegal   (DECODER_STAGE_PERF_EN only) saturating count of illegal pops
// Optional feature macro: DECODER_STAGE_PERF_EN.
// Encodings:
//   alu_oper   ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
//              MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17
//   next_stage FETCH=0 WB=1 BRANCH=2 LOAD=3 STORE=4 SYSTEM=5 TRAP=6
//   alu_s1_sel REGVAL1=0 PC=1;  alu_s2_sel REGVAL2=0 IMM=1
//   reg_input_sel ALU=0 IMM=1 PC+4=2 MEM=3
module decoder_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned M_EXT = 1,
    parameter int unsigned XLEN  = 32
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    decoder_stage_if.slave bus
`ifdef DECODER_STAGE_PERF_EN
    ,
    output logic [31:0]    O_perf_decoded,
    output logic [15:0]    O_perf_illegal
`endif
);

    generate
        if (XLEN != 32) begin : g_xlen_chk
            $error("decoder_stage: only XLEN=32 is supported");
        end
        if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("decoder_stage: DEPTH must be a power of two >= 1");
        end
    endgenerate

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    localparam logic [2:0] NS_FETCH  = 3'd0;
    localparam logic [2:0] NS_WB     = 3'd1;
    localparam logic [2:0] NS_BRANCH = 3'd2;
    localparam logic [2:0] NS_LOAD   = 3'd3;
    localparam logic [2:0] NS_STORE  = 3'd4;
    localparam logic [2:0] NS_SYSTEM = 3'd5;
    localparam logic [2:0] NS_TRAP   = 3'd6;

    localparam logic       S1_PC   = 1'b1;
    localparam logic [1:0] S2_IMM  = 2'd1;
    localparam logic [1:0] RIS_IMM = 2'd1;
    localparam logic [1:0] RIS_PC4 = 2'd2;
    localparam logic [1:0] RIS_MEM = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [5:0]      branchmask;
        logic [2:0]      funct3;
        logic [4:0]      alu_oper;
        logic            alu_s1_sel;
        logic [1:0]      alu_s2_sel;
        logic [2:0]      next_stage;
        logic            wb_from_alu;
        logic            wb_from_imm;
        logic            next_pc_from_alu;
        logic [1:0]      reg_input_sel;
        logic            illegal;
    } entry_t;

    // Base integer ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            illegal;
    entry_t          dec;

    assign instr  = bus.I_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Combinational decode of the fetch-side instruction into a FIFO entry.
    always_comb begin
        dec        = '0;
        illegal    = 1'b0;
        dec.pc     = bus.I_pc;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        case (opcode)
            OPC_LUI: begin
                dec.imm           = imm_u;
                dec.wb_from_imm   = 1'b1;
                dec.reg_input_sel = RIS_IMM;
                dec.next_stage    = NS_WB;
            end
            OPC_AUIPC: begin
                dec.imm         = imm_u;
                dec.alu_s1_sel  = S1_PC;
                dec.alu_s2_sel  = S2_IMM;
                dec.wb_from_alu = 1'b1;
                dec.next_stage  = NS_WB;
            end
            OPC_JAL: begin
                dec.imm              = imm_j;
                dec.alu_s1_sel       = S1_PC;
                dec.alu_s2_sel       = S2_IMM;
                dec.next_pc_from_alu = 1'b1;
                dec.reg_input_sel    = RIS_PC4;
                dec.next_stage       = NS_WB;
            end
            OPC_JALR: begin
                dec.imm              = imm_i;
                dec.alu_s2_sel       = S2_IMM;
                dec.next_pc_from_alu = 1'b1;
                dec.reg_input_sel    = RIS_PC4;
                dec.next_stage       = NS_WB;
                if (f3 != 3'b000) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm        = imm_b;
                dec.alu_oper   = ALU_SUB;
                dec.next_stage = NS_BRANCH;
                case (f3)
                    3'b000:  dec.branchmask = 6'b000001;
                    3'b001:  dec.branchmask = 6'b000010;
                    3'b100:  dec.branchmask = 6'b000100;
                    3'b101:  dec.branchmask = 6'b001000;
                    3'b110:  dec.branchmask = 6'b010000;
                    3'b111:  dec.branchmask = 6'b100000;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm           = imm_i;
                dec.alu_s2_sel    = S2_IMM;
                dec.reg_input_sel = RIS_MEM;
                dec.next_stage    = NS_LOAD;
            end
            OPC_STORE: begin
                dec.imm        = imm_s;
                dec.alu_s2_sel = S2_IMM;
                dec.next_stage = NS_STORE;
            end
            OPC_OPIMM: begin
                dec.imm         = imm_i;
                dec.alu_s2_sel  = S2_IMM;
                dec.wb_from_alu = 1'b1;
                dec.next_stage  = NS_WB;
                // Shift-immediates reuse instr[31:25] as funct7.
                if (f3 == 3'b001) begin
                    dec.alu_oper = ALU_SLL;
                    if (f7 != 7'b0000000) illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    case (f7)
                        7'b0000000: dec.alu_oper = ALU_SRL;
                        7'b0100000: dec.alu_oper = ALU_SRA;
                        default:    illegal = 1'b1;
                    endcase
                end else begin
                    dec.alu_oper = alu_base(f3, 1'b0);
                end
            end
            OPC_OP: begin
                dec.wb_from_alu = 1'b1;
                dec.next_stage  = NS_WB;
                case (f7)
                    7'b0000000: dec.alu_oper = alu_base(f3, 1'b0);
                    7'b0100000: begin
                        if (f3 == 3'b000 || f3 == 3'b101) dec.alu_oper = alu_base(f3, 1'b1);
                        else                              illegal = 1'b1;
                    end
                    7'b0000001: begin
                        if (M_EXT != 0) dec.alu_oper = ALU_MUL + 5'(f3);
                        else            illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_MISCMEM: dec.next_stage = NS_FETCH;
            OPC_SYSTEM: begin
                dec.imm        = imm_i;
                dec.next_stage = NS_SYSTEM;
            end
            default: illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) illegal = 1'b1;
        if (illegal) begin
            dec.illegal          = 1'b1;
            dec.next_stage       = NS_TRAP;
            dec.wb_from_alu      = 1'b0;
            dec.wb_from_imm      = 1'b0;
            dec.next_pc_from_alu = 1'b0;
        end
    end

    entry_t          mem_q [DEPTH];
    entry_t          hold_q, hold_d;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready;
    logic            valid;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake state depends only on registered occupancy.
    assign ready = (count_q != CW'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = bus.I_valid && ready && !bus.I_flush;
    assign pop   = valid && bus.I_ready && !bus.I_flush;

    // Pointer/occupancy next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (bus.I_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                hold_d   = mem_q[rd_ptr_q];
            end
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: it is only visible while count_q is non-zero.
    always_ff @(posedge I_clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // Empty FIFO shows the last popped entry (all-zero after reset).
    always_comb begin
        head = hold_q;
        if (valid) head = mem_q[rd_ptr_q];
    end

    assign bus.O_ready            = ready;
    assign bus.O_valid            = valid;
    assign bus.O_pc               = head.pc;
    assign bus.O_rs1              = head.rs1;
    assign bus.O_rs2              = head.rs2;
    assign bus.O_rd               = head.rd;
    assign bus.O_imm              = head.imm;
    assign bus.O_branchmask       = head.branchmask;
    assign bus.O_funct3           = head.funct3;
    assign bus.O_alu_oper         = head.alu_oper;
    assign bus.O_alu_s1_sel       = head.alu_s1_sel;
    assign bus.O_alu_s2_sel       = head.alu_s2_sel;
    assign bus.O_next_stage       = head.next_stage;
    assign bus.O_wb_from_alu      = head.wb_from_alu;
    assign bus.O_wb_from_imm      = head.wb_from_imm;
    assign bus.O_next_pc_from_alu = head.next_pc_from_alu;
    assign bus.O_reg_input_sel    = head.reg_input_sel;
    assign bus.O_illegal          = head.illegal;

`ifdef DECODER_STAGE_PERF_EN
    logic [31:0] perf_dec_q;
    logic [15:0] perf_ill_q;

    // Saturating pop counters; flush does not touch them.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            perf_dec_q <= '0;
            perf_ill_q <= '0;
        end else if (pop) begin
            if (head.illegal) begin
                if (perf_ill_q != '1) perf_ill_q <= perf_ill_q + 16'd1;
            end else begin
                if (perf_dec_q != '1) perf_dec_q <= perf_dec_q + 32'd1;
            end
        end
    end

    assign O_perf_decoded = perf_dec_q;
    assign O_perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_decoder_stage.sv
// tb_decoder_stage: directed self-checking bench for decoder_stage
// (DEPTH=2, M_EXT=1 main instance plus an M_EXT=0 instance sharing inputs).
module tb_decoder_stage;
    localparam int unsigned XLEN = 32;

    localparam logic [4:0] A_ADD = 5'd0;
    localparam logic [4:0] A_SUB = 5'd1;
    localparam logic [4:0] A_SRA = 5'd7;
    localparam logic [4:0] A_MUL = 5'd10;
    localparam logic [2:0] N_FETCH = 3'd0;
    localparam logic [2:0] N_WB = 3'd1;
    localparam logic [2:0] N_BRANCH = 3'd2;
    localparam logic [2:0] N_SYSTEM = 3'd5;
    localparam logic [2:0] N_TRAP = 3'd6;

    localparam int NV = 11;
    localparam logic [31:0] TV_INSTR [NV] = '{
        32'h402081B3, 32'h4020A1B3, 32'h0020A463, 32'h000090E7, 32'h000080E7,
        32'h4030D093, 32'h40309093, 32'h00000000, 32'h0000000F, 32'h00000073,
        32'h002081B1};
    localparam logic TV_ILL [NV] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    localparam logic [2:0] TV_NS [NV] = '{
        N_WB, N_TRAP, N_TRAP, N_TRAP, N_WB, N_WB, N_TRAP, N_TRAP, N_FETCH, N_SYSTEM, N_TRAP};
    localparam logic [4:0] TV_ALU [NV] = '{
        A_SUB, 5'd0, 5'd0, 5'd0, A_ADD, A_SRA, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decoder_stage_if #(.XLEN(XLEN)) bus ();
    decoder_stage_if #(.XLEN(XLEN)) bus_nm ();

    assign bus_nm.I_flush = bus.I_flush;
    assign bus_nm.I_valid = bus.I_valid;
    assign bus_nm.I_instr = bus.I_instr;
    assign bus_nm.I_pc    = bus.I_pc;
    assign bus_nm.I_ready = bus.I_ready;

`ifdef DECODER_STAGE_PERF_EN
    logic [31:0] perf_dec, perf_dec_nm;
    logic [15:0] perf_ill, perf_ill_nm;
`endif

    decoder_stage #(.DEPTH(2), .M_EXT(1), .XLEN(XLEN)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
`ifdef DECODER_STAGE_PERF_EN
        ,
        .O_perf_decoded (perf_dec),
        .O_perf_illegal (perf_ill)
`endif
    );

    decoder_stage #(.DEPTH(2), .M_EXT(0), .XLEN(XLEN)) dut_nm (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus_nm)
`ifdef DECODER_STAGE_PERF_EN
        ,
        .O_perf_decoded (perf_dec_nm),
        .O_perf_illegal (perf_ill_nm)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for one cycle (caller controls I_ready).
    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        bus.I_valid = 1'b1;
        bus.I_instr = ins;
        bus.I_pc    = pc;
        tick();
        bus.I_valid = 1'b0;
    endtask

    task automatic pop();
        bus.I_ready = 1'b1;
        tick();
        bus.I_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.O_valid, bus.O_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_handshake got valid/ready=%b want 01", {bus.O_valid, bus.O_ready});
        end
        vectors++;
        if ({bus.O_pc, bus.O_imm, bus.O_alu_oper, bus.O_next_stage, bus.O_rd, bus.O_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_bundle got pc=%h imm=%h alu=%0d ns=%0d want all zero",
                     bus.O_pc, bus.O_imm, bus.O_alu_oper, bus.O_next_stage);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        bus.I_ready = 1'b1;
        push(32'h002081B3, 32'h100);
        vectors++;
        if ({bus.O_valid, bus.O_rd, bus.O_rs1, bus.O_rs2} !== {1'b1, 5'd3, 5'd1, 5'd2}) begin
            errors++;
            $display("FAIL add_regs got v=%b rd=%0d rs1=%0d rs2=%0d want 1/3/1/2",
                     bus.O_valid, bus.O_rd, bus.O_rs1, bus.O_rs2);
        end
        vectors++;
        if ({bus.O_alu_oper, bus.O_wb_from_alu, bus.O_illegal, bus.O_next_stage, bus.O_alu_s2_sel}
            !== {A_ADD, 1'b1, 1'b0, N_WB, 2'd0}) begin
            errors++;
            $display("FAIL add_ctrl got alu=%0d wb=%b ill=%b ns=%0d s2=%0d want 0/1/0/1/0",
                     bus.O_alu_oper, bus.O_wb_from_alu, bus.O_illegal, bus.O_next_stage, bus.O_alu_s2_sel);
        end
        vectors++;
        if (bus.O_pc !== 32'h100) begin
            errors++;
            $display("FAIL add_pc got %h want 00000100", bus.O_pc);
        end
        tick();
        bus.I_ready = 1'b0;
        vectors++;
        if ({bus.O_valid, bus.O_pc} !== {1'b0, 32'h100}) begin
            errors++;
            $display("FAIL add_pop_hold got v=%b pc=%h want 0/00000100", bus.O_valid, bus.O_pc);
        end
    endtask

    task automatic test_fill_order();
        bus.I_ready = 1'b0;
        bus.I_valid = 1'b1;
        bus.I_instr = 32'h00500093;
        bus.I_pc    = 32'h104;
        tick();
        vectors++;
        if ({bus.O_ready, bus.O_valid, bus.O_imm} !== {2'b11, 32'd5}) begin
            errors++;
            $display("FAIL fill_one got rdy=%b v=%b imm=%h want 1/1/5", bus.O_ready, bus.O_valid, bus.O_imm);
        end
        bus.I_instr = 32'h123452B7;
        bus.I_pc    = 32'h108;
        tick();
        // Offered while full: must be dropped.
        bus.I_instr = 32'h00700093;
        bus.I_pc    = 32'h10C;
        vectors++;
        if ({bus.O_ready, bus.O_imm, bus.O_pc} !== {1'b0, 32'd5, 32'h104}) begin
            errors++;
            $display("FAIL fill_full got rdy=%b imm=%h pc=%h want 0/5/104", bus.O_ready, bus.O_imm, bus.O_pc);
        end
        tick();
        bus.I_valid = 1'b0;
        vectors++;
        if ({bus.O_ready, bus.O_alu_s2_sel, bus.O_alu_oper, bus.O_rd} !== {1'b0, 2'd1, A_ADD, 5'd1}) begin
            errors++;
            $display("FAIL fill_hold got rdy=%b s2=%0d alu=%0d rd=%0d want 0/1/0/1",
                     bus.O_ready, bus.O_alu_s2_sel, bus.O_alu_oper, bus.O_rd);
        end
        bus.I_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.O_valid, bus.O_ready, bus.O_imm, bus.O_rd, bus.O_pc} !== {2'b11, 32'h12345000, 5'd5, 32'h108}) begin
            errors++;
            $display("FAIL fill_second got v=%b rdy=%b imm=%h rd=%0d pc=%h want 1/1/12345000/5/108",
                     bus.O_valid, bus.O_ready, bus.O_imm, bus.O_rd, bus.O_pc);
        end
        vectors++;
        if ({bus.O_wb_from_imm, bus.O_wb_from_alu, bus.O_alu_s1_sel, bus.O_alu_s2_sel, bus.O_reg_input_sel}
            !== {1'b1, 1'b0, 1'b0, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL lui_ctrl got wbi=%b wba=%b s1=%b s2=%0d ris=%0d want 1/0/0/0/1",
                     bus.O_wb_from_imm, bus.O_wb_from_alu, bus.O_alu_s1_sel, bus.O_alu_s2_sel, bus.O_reg_input_sel);
        end
        tick();
        bus.I_ready = 1'b0;
        vectors++;
        if ({bus.O_valid, bus.O_ready} !== 2'b01) begin
            errors++;
            $display("FAIL fill_drain got v/rdy=%b want 01 (dropped entry emerged?)", {bus.O_valid, bus.O_ready});
        end
    endtask

    task automatic test_back_to_back();
        bus.I_ready = 1'b1;
        bus.I_valid = 1'b1;
        bus.I_instr = 32'h00100093;
        tick();
        bus.I_instr = 32'h00200093;
        vectors++;
        if ({bus.O_valid, bus.O_imm} !== {1'b1, 32'd1}) begin
            errors++;
            $display("FAIL b2b_first got v=%b imm=%h want 1/1", bus.O_valid, bus.O_imm);
        end
        tick();
        bus.I_instr = 32'h00300093;
        vectors++;
        if ({bus.O_valid, bus.O_ready, bus.O_imm} !== {2'b11, 32'd2}) begin
            errors++;
            $display("FAIL b2b_second got v=%b rdy=%b imm=%h want 1/1/2", bus.O_valid, bus.O_ready, bus.O_imm);
        end
        tick();
        bus.I_valid = 1'b0;
        vectors++;
        if ({bus.O_valid, bus.O_imm} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL b2b_third got v=%b imm=%h want 1/3", bus.O_valid, bus.O_imm);
        end
        tick();
        bus.I_ready = 1'b0;
        vectors++;
        if (bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got v=%b want 0", bus.O_valid);
        end
    endtask

    task automatic test_branch();
        bus.I_ready = 1'b0;
        push(32'h00208463, 32'h200);
        vectors++;
        if ({bus.O_imm, bus.O_branchmask, bus.O_next_stage, bus.O_illegal} !== {32'd8, 6'b000001, N_BRANCH, 1'b0}) begin
            errors++;
            $display("FAIL beq got imm=%h mask=%b ns=%0d ill=%b want 8/000001/2/0",
                     bus.O_imm, bus.O_branchmask, bus.O_next_stage, bus.O_illegal);
        end
        pop();
    endtask

    task automatic test_mext();
        bus.I_ready = 1'b0;
        push(32'h022081B3, 32'h300);
        vectors++;
        if ({bus.O_alu_oper, bus.O_illegal, bus.O_next_stage} !== {A_MUL, 1'b0, N_WB}) begin
            errors++;
            $display("FAIL mul_mext1 got alu=%0d ill=%b ns=%0d want 10/0/1",
                     bus.O_alu_oper, bus.O_illegal, bus.O_next_stage);
        end
        vectors++;
        if ({bus_nm.O_illegal, bus_nm.O_next_stage, bus_nm.O_wb_from_alu} !== {1'b1, N_TRAP, 1'b0}) begin
            errors++;
            $display("FAIL mul_mext0 got ill=%b ns=%0d wb=%b want 1/6/0",
                     bus_nm.O_illegal, bus_nm.O_next_stage, bus_nm.O_wb_from_alu);
        end
        pop();
    endtask

    task automatic test_illegal();
        bus.I_ready = 1'b0;
        for (int i = 0; i < NV; i++) begin
            push(TV_INSTR[i], 32'h400 + 32'(i * 4));
            vectors++;
            if ({bus.O_illegal, bus.O_next_stage} !== {TV_ILL[i], TV_NS[i]}) begin
                errors++;
                $display("FAIL decode_%0d instr=%h got ill=%b ns=%0d want ill=%b ns=%0d",
                         i, TV_INSTR[i], bus.O_illegal, bus.O_next_stage, TV_ILL[i], TV_NS[i]);
            end
            if (TV_ILL[i]) begin
                vectors++;
                if ({bus.O_wb_from_alu, bus.O_wb_from_imm, bus.O_next_pc_from_alu} !== 3'b000) begin
                    errors++;
                    $display("FAIL decode_wb_%0d instr=%h got wb flags=%b want 000", i, TV_INSTR[i],
                             {bus.O_wb_from_alu, bus.O_wb_from_imm, bus.O_next_pc_from_alu});
                end
            end else begin
                vectors++;
                if (bus.O_alu_oper !== TV_ALU[i]) begin
                    errors++;
                    $display("FAIL decode_alu_%0d instr=%h got alu=%0d want %0d",
                             i, TV_INSTR[i], bus.O_alu_oper, TV_ALU[i]);
                end
            end
            pop();
        end
    endtask

    task automatic test_flush();
        bus.I_ready = 1'b0;
        push(32'h00500093, 32'h500);
        push(32'h123452B7, 32'h504);
        vectors++;
        if (bus.O_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full got rdy=%b want 0", bus.O_ready);
        end
        bus.I_flush = 1'b1;
        push(32'h00900093, 32'h508);
        bus.I_flush = 1'b0;
        vectors++;
        if ({bus.O_valid, bus.O_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_empty got v/rdy=%b want 01", {bus.O_valid, bus.O_ready});
        end
        bus.I_ready = 1'b1;
        tick();
        tick();
        bus.I_ready = 1'b0;
        vectors++;
        if (bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped got v=%b imm=%h want 0", bus.O_valid, bus.O_imm);
        end
        push(32'h00300093, 32'h50C);
        vectors++;
        if ({bus.O_valid, bus.O_imm, bus.O_pc} !== {1'b1, 32'd3, 32'h50C}) begin
            errors++;
            $display("FAIL flush_resume got v=%b imm=%h pc=%h want 1/3/50c", bus.O_valid, bus.O_imm, bus.O_pc);
        end
        pop();
    endtask

    task automatic test_async_reset();
        bus.I_ready = 1'b0;
        push(32'h00500093, 32'h600);
        vectors++;
        if (bus.O_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got v=%b want 1", bus.O_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.O_valid, bus.O_ready, bus.O_imm} !== {2'b01, 32'd0}) begin
            errors++;
            $display("FAIL areset_mid got v=%b rdy=%b imm=%h want 0/1/0", bus.O_valid, bus.O_ready, bus.O_imm);
        end
`ifdef DECODER_STAGE_PERF_EN
        vectors++;
        if ({perf_dec, perf_ill} !== '0) begin
            errors++;
            $display("FAIL perf_reset got dec=%0d ill=%0d want 0/0", perf_dec, perf_ill);
        end
`endif
        tick();
        vectors++;
        if (bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_held got v=%b want 0", bus.O_valid);
        end
        rst_n = 1'b1;
        tick();
`ifdef DECODER_STAGE_PERF_EN
        push(32'h00500093, 32'h700);
        pop();
        push(32'h00000000, 32'h704);
        pop();
        vectors++;
        if ({perf_dec, perf_ill} !== {32'd1, 16'd1}) begin
            errors++;
            $display("FAIL perf_count got dec=%0d ill=%0d want 1/1", perf_dec, perf_ill);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.I_flush = 1'b0;
        bus.I_valid = 1'b0;
        bus.I_instr = '0;
        bus.I_pc    = '0;
        bus.I_ready = 1'b0;
        test_reset();
        test_add();
        test_fill_order();
        test_back_to_back();
        test_branch();
        test_mext();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
